// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment page scheduler: page indices,
// scheduler FSM states and the flag bit that selects result-page blinking.
package seg7_pkg;

    localparam logic [1:0] PG_A   = 2'd0;
    localparam logic [1:0] PG_B   = 2'd1;
    localparam logic [1:0] PG_RES = 2'd2;
    localparam logic [1:0] PG_FLG = 2'd3;

    localparam int FLG_OVF = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } sched_state_t;

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero blanking mask: digit k lights when any nibble at index >= k
// of the value is nonzero; the least-significant digit is always lit.
module seg7_lz_mask (
    input  logic [15:0] value,
    output logic [3:0]  mask
);

    assign mask[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : gen_digit
            assign mask[gi] = |value[15:4*gi];
        end
    endgenerate

endmodule

// File: rtl/seg7_page_sched.sv
// Rotates snapshotted ALU operands, result and flags across display pages,
// with leading-zero blanking and an overflow blink on the result page.
module seg7_page_sched
    import seg7_pkg::*;
#(
    parameter int DWELL      = 50_000_000,
    parameter int BLINK_HALF = 12_500_000,
    parameter int CNT_W      = 26
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [15:0] iOPA,
    input  logic [15:0] iOPB,
    input  logic [15:0] iRES,
    input  logic [3:0]  iFLAGS,
    input  logic        iVALID,
    output logic        oACK,
    input  logic        iLOCK,
    input  logic        iPAGE_REQ,
    input  logic [1:0]  iPAGE_SEL,
    output logic [15:0] oDIG,
    output logic [7:0]  oON_OFF,
    output logic [1:0]  oPAGE
);

    sched_state_t stateReg, stateNext;
    logic [15:0]  opAReg, opANext;
    logic [15:0]  opBReg, opBNext;
    logic [15:0]  resReg, resNext;
    logic [3:0]   flagsReg, flagsNext;
    logic [1:0]   pageNext;
    logic [CNT_W-1:0] dwellReg, dwellNext;
    logic [CNT_W-1:0] blinkReg, blinkNext;
    logic         phaseReg, phaseNext;
    logic [15:0]  shownNext;
    logic [3:0]   lzMask;
    logic [3:0]   blinkGate;
    logic [15:0]  digNext;
    logic [7:0]   onOffNext;

    always_comb begin
        opANext   = iVALID ? iOPA   : opAReg;
        opBNext   = iVALID ? iOPB   : opBReg;
        resNext   = iVALID ? iRES   : resReg;
        flagsNext = iVALID ? iFLAGS : flagsReg;

        stateNext = stateReg;
        pageNext  = oPAGE;
        dwellNext = dwellReg;
        if (stateReg == IDLE) begin
            // A page request only counts once a snapshot has been taken.
            if (iVALID) begin
                stateNext = SHOW;
                pageNext  = iPAGE_REQ ? iPAGE_SEL : PG_RES;
                dwellNext = '0;
            end
        end else if (iPAGE_REQ) begin
            pageNext  = iPAGE_SEL;
            dwellNext = '0;
        end else if (iVALID) begin
            pageNext  = PG_RES;
            dwellNext = '0;
        end else if (!iLOCK) begin
            if (dwellReg == CNT_W'(DWELL - 1)) begin
                pageNext  = oPAGE + 2'd1;
                dwellNext = '0;
            end else begin
                dwellNext = dwellReg + CNT_W'(1);
            end
        end

        if (blinkReg == CNT_W'(BLINK_HALF - 1)) begin
            blinkNext = '0;
            phaseNext = ~phaseReg;
        end else begin
            blinkNext = blinkReg + CNT_W'(1);
            phaseNext = phaseReg;
        end

        case (pageNext)
            PG_A:    shownNext = opANext;
            PG_B:    shownNext = opBNext;
            PG_RES:  shownNext = resNext;
            default: shownNext = {12'h000, flagsNext};
        endcase

        blinkGate = (pageNext == PG_RES && flagsNext[FLG_OVF]) ? {4{phaseNext}} : 4'hF;
        digNext   = (stateNext == SHOW) ? shownNext : 16'h0000;
        onOffNext = (stateNext == SHOW) ? {4'h0, lzMask & blinkGate} : 8'h00;
    end

    seg7_lz_mask uLzMask (
        .value (shownNext),
        .mask  (lzMask)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stateReg <= IDLE;
            opAReg   <= '0;
            opBReg   <= '0;
            resReg   <= '0;
            flagsReg <= '0;
            dwellReg <= '0;
            blinkReg <= '0;
            phaseReg <= 1'b1;
            oPAGE    <= PG_A;
            oDIG     <= '0;
            oON_OFF  <= '0;
            oACK     <= 1'b0;
        end else begin
            stateReg <= stateNext;
            opAReg   <= opANext;
            opBReg   <= opBNext;
            resReg   <= resNext;
            flagsReg <= flagsNext;
            dwellReg <= dwellNext;
            blinkReg <= blinkNext;
            phaseReg <= phaseNext;
            oPAGE    <= pageNext;
            oDIG     <= digNext;
            oON_OFF  <= onOffNext;
            oACK     <= iVALID;
        end
    end

endmodule

// File: tb/tb_seg7_page_sched.sv
// Directed bench for seg7_page_sched with DWELL=4 and BLINK_HALF=2.
module tb_seg7_page_sched;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [15:0] iOPA, iOPB, iRES;
    logic [3:0]  iFLAGS;
    logic        iVALID, iLOCK, iPAGE_REQ;
    logic [1:0]  iPAGE_SEL;
    logic        oACK;
    logic [15:0] oDIG;
    logic [7:0]  oON_OFF;
    logic [1:0]  oPAGE;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int edgeCnt = 0;

    seg7_page_sched #(.DWELL(4), .BLINK_HALF(2), .CNT_W(4)) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iOPA      (iOPA),
        .iOPB      (iOPB),
        .iRES      (iRES),
        .iFLAGS    (iFLAGS),
        .iVALID    (iVALID),
        .oACK      (oACK),
        .iLOCK     (iLOCK),
        .iPAGE_REQ (iPAGE_REQ),
        .iPAGE_SEL (iPAGE_SEL),
        .oDIG      (oDIG),
        .oON_OFF   (oON_OFF),
        .oPAGE     (oPAGE)
    );

    always #5 iCLK = ~iCLK;

    // Edges since reset release; the blink phase is 1 for edge counts 0-1, 0 for 2-3, ...
    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) edgeCnt <= 0;
        else         edgeCnt <= edgeCnt + 1;
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkView(input string tag, input logic [1:0] pg, input logic [15:0] dig,
                           input logic [7:0] onOff);
        $display("t=%0t %s page=%0d dig=%h on_off=%h ack=%b", $time, tag, oPAGE, oDIG, oON_OFF, oACK);
        chk({tag, " page"},   {30'd0, oPAGE}, {30'd0, pg});
        chk({tag, " dig"},    {16'd0, oDIG},  {16'd0, dig});
        chk({tag, " on_off"}, {24'd0, oON_OFF}, {24'd0, onOff});
    endtask

    task automatic snap(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                        input logic [3:0] f);
        iOPA = a; iOPB = b; iRES = r; iFLAGS = f; iVALID = 1'b1;
    endtask

    initial begin
        logic [7:0] expOn;
        iRST_N = 1'b0;
        iOPA = '0; iOPB = '0; iRES = '0; iFLAGS = '0;
        iVALID = 1'b0; iLOCK = 1'b0; iPAGE_REQ = 1'b0; iPAGE_SEL = '0;
        step(); step(); step();
        chkView("reset", 2'd0, 16'h0000, 8'h00);
        chk("reset ack", {31'd0, oACK}, 32'd0);
        iRST_N = 1'b1;

        // 1: idle for 20 cycles stays blank
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle outs", {8'd0, oDIG, oON_OFF}, 32'd0);
            chk("idle page", {30'd0, oPAGE}, 32'd0);
        end

        // 2: first snapshot and rotation
        snap(16'h1234, 16'h0056, 16'h0007, 4'h0);
        step(); iVALID = 1'b0;
        chk("snap ack", {31'd0, oACK}, 32'd1);
        chkView("snap res", 2'd2, 16'h0007, 8'h01);
        step();
        chk("ack drop", {31'd0, oACK}, 32'd0);
        step(); step();
        chkView("dwell end", 2'd2, 16'h0007, 8'h01);
        step();
        chkView("rot flg", 2'd3, 16'h0000, 8'h01);
        step(); step(); step(); step();
        chkView("rot A", 2'd0, 16'h1234, 8'h0F);
        step(); step(); step(); step();
        chkView("rot B", 2'd1, 16'h0056, 8'h03);

        // 3: lock on page 0 (reach it at dwell count 0)
        for (int i = 0; i < 12; i++) step();
        chkView("pre lock", 2'd0, 16'h1234, 8'h0F);
        iLOCK = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("locked page", {30'd0, oPAGE}, 32'd0);
        end
        iLOCK = 1'b0;
        step(); step(); step();
        chk("unlock hold", {30'd0, oPAGE}, 32'd0);
        step();
        chkView("unlock adv", 2'd1, 16'h0056, 8'h03);

        // 4: overflow blink on result page only
        snap(16'h00A0, 16'h0000, 16'h8000, 4'h1);
        step(); iVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expOn = (((edgeCnt >> 1) & 1) == 0) ? 8'h0F : 8'h00;
            chkView("blink res", 2'd2, 16'h8000, expOn);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chkView("no blink flg", 2'd3, 16'h0001, 8'h01);
            step();
        end
        chkView("no blink A", 2'd0, 16'h00A0, 8'h03);

        // 5: page request coinciding with snapshot
        snap(16'h0001, 16'hBEEF, 16'h0000, 4'h0);
        iPAGE_REQ = 1'b1; iPAGE_SEL = 2'd1;
        step(); iVALID = 1'b0; iPAGE_REQ = 1'b0;
        chk("req+snap ack", {31'd0, oACK}, 32'd1);
        chkView("req+snap", 2'd1, 16'hBEEF, 8'h0F);
        step(); step(); step(); step();
        chkView("after req", 2'd2, 16'h0000, 8'h01);
        iPAGE_REQ = 1'b1; iPAGE_SEL = 2'd0;
        step(); iPAGE_REQ = 1'b0;
        chkView("manual A", 2'd0, 16'h0001, 8'h01);

        // back-to-back snapshots
        snap(16'h0001, 16'hBEEF, 16'h0011, 4'h0);
        step();
        chk("b2b ack1", {31'd0, oACK}, 32'd1);
        chkView("b2b 1", 2'd2, 16'h0011, 8'h03);
        iRES = 16'h0022;
        step(); iVALID = 1'b0;
        chk("b2b ack2", {31'd0, oACK}, 32'd1);
        chkView("b2b 2", 2'd2, 16'h0022, 8'h03);
        step();
        chk("b2b ack end", {31'd0, oACK}, 32'd0);

        // 6: reset mid-dwell on page 0
        iPAGE_REQ = 1'b1; iPAGE_SEL = 2'd0;
        step(); iPAGE_REQ = 1'b0;
        chkView("pre rst", 2'd0, 16'h0001, 8'h01);
        step(); step();
        iRST_N = 1'b0;
        #1;
        chkView("async rst", 2'd0, 16'h0000, 8'h00);
        chk("async rst ack", {31'd0, oACK}, 32'd0);
        step(); step();
        iRST_N = 1'b1;
        iPAGE_REQ = 1'b1; iPAGE_SEL = 2'd3;
        step(); iPAGE_REQ = 1'b0;
        chkView("idle req", 2'd0, 16'h0000, 8'h00);
        snap(16'h0000, 16'h0000, 16'h0100, 4'h0);
        step(); iVALID = 1'b0;
        chk("restart ack", {31'd0, oACK}, 32'd1);
        chkView("restart", 2'd2, 16'h0100, 8'h07);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
